flag_branch_unit: RTL and testbench

- Consumer end of the ALU flag interface.
- Holds the architectural Z/V/N flag register and applies the per-opcode flag write rules.
- Resolves conditional branches against those flags and computes the next PC.
- Sits between EX (flag producer) and fetch (PC consumer); registered outputs, one-cycle resolve latency, one extra cycle on a same-cycle flag/branch conflict.

---
 rtl/flag_branch_unit.sv | 159 +++++++++++++++
 tb/tb_flag_branch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Z/V/N flag register plus conditional-branch resolver feeding the fetch PC.
// Optional macro FLAG_BYPASS_EN resolves flag/branch conflicts through the incoming flags instead of HOLD.
module flag_branch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        flag_wr_valid,
  input  logic [2:0]  alu_opcode,
  input  logic [2:0]  alu_flags,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  input  logic [15:0] br_pc_plus2,
  input  logic [8:0]  br_imm,
  output logic        br_ready,
  output logic        br_done,
  output logic        br_taken,
  output logic [15:0] br_pc_next,
  output logic [2:0]  flags
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      r_state, w_stateNext;
  logic [2:0]  r_flags, w_flagsNext;
  logic [2:0]  r_cond;
  logic [15:0] r_pcPlus2;
  logic [8:0]  r_imm;
  logic        r_done, r_taken;
  logic [15:0] r_pcNext;

  logic        w_accept, w_conflict, w_resolve, w_taken;
  logic [2:0]  w_resCond, w_resFlags;
  logic [15:0] w_resPc, w_target;
  logic [8:0]  w_resImm;

  function automatic logic condTrue(input logic [2:0] cond, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (cond)
      3'b000:  condTrue = !z;
      3'b001:  condTrue = z;
      3'b010:  condTrue = !z && !n;
      3'b011:  condTrue = n;
      3'b100:  condTrue = z || !n;
      3'b101:  condTrue = n || z;
      3'b110:  condTrue = v;
      default: condTrue = 1'b1;
    endcase
  endfunction

  // ADD/SUB write all flags; logic/shift ops write Z only; RED/PADSUB write none.
  always_comb begin
    w_flagsNext = r_flags;
    if (flag_wr_valid) begin
      case (alu_opcode)
        3'b000, 3'b001:                 w_flagsNext = alu_flags;
        3'b010, 3'b100, 3'b101, 3'b110: w_flagsNext = {alu_flags[2], r_flags[1:0]};
        default:                        w_flagsNext = r_flags;
      endcase
    end
  end

  assign br_ready = (r_state == IDLE);
  assign w_accept = br_valid && br_ready && !stall;
`ifdef FLAG_BYPASS_EN
  assign w_conflict = 1'b0;
`else
  assign w_conflict = flag_wr_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_state <= IDLE;
    else if (!stall) r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (flush) begin
      w_stateNext = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept && w_conflict) w_stateNext = HOLD;
        HOLD:    w_stateNext = IDLE;
        default: w_stateNext = IDLE;
      endcase
    end
  end

  // Resolution operands: captured copy in HOLD, live request otherwise.
  always_comb begin
    w_resCond  = br_cond;
    w_resPc    = br_pc_plus2;
    w_resImm   = br_imm;
`ifdef FLAG_BYPASS_EN
    w_resFlags = w_flagsNext;
`else
    w_resFlags = r_flags;
`endif
    w_resolve  = 1'b0;
    if (r_state == HOLD) begin
      w_resCond  = r_cond;
      w_resPc    = r_pcPlus2;
      w_resImm   = r_imm;
      w_resFlags = r_flags;
      w_resolve  = !stall && !flush;
    end else begin
      w_resolve  = w_accept && !w_conflict && !flush;
    end
    w_taken  = condTrue(w_resCond, w_resFlags);
    w_target = w_taken ? (w_resPc + {{6{w_resImm[8]}}, w_resImm, 1'b0}) : w_resPc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_flags <= 3'b000;
    else if (!stall) r_flags <= w_flagsNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cond    <= 3'b000;
      r_pcPlus2 <= 16'h0000;
      r_imm     <= 9'h000;
    end else if (!stall) begin
      if (flush) begin
        r_cond    <= 3'b000;
        r_pcPlus2 <= 16'h0000;
        r_imm     <= 9'h000;
      end else if (r_state == IDLE && w_accept && w_conflict) begin
        r_cond    <= br_cond;
        r_pcPlus2 <= br_pc_plus2;
        r_imm     <= br_imm;
      end
    end
  end

  // Taken/target hold their last resolved value; only br_done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done   <= 1'b0;
      r_taken  <= 1'b0;
      r_pcNext <= 16'h0000;
    end else if (!stall) begin
      r_done <= w_resolve;
      if (w_resolve) begin
        r_taken  <= w_taken;
        r_pcNext <= w_target;
      end
    end
  end

  assign br_done    = r_done;
  assign br_taken   = r_taken;
  assign br_pc_next = r_pcNext;
  assign flags      = r_flags;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: flag write rules, branch resolve, conflict/HOLD, flush, stall, reset.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, flag_wr_valid, br_valid;
  logic [2:0]  alu_opcode, alu_flags, br_cond;
  logic [15:0] br_pc_plus2;
  logic [8:0]  br_imm;
  logic        br_ready, br_done, br_taken;
  logic [15:0] br_pc_next;
  logic [2:0]  flags;

  int compared = 0;
  int mismatched = 0;

  flag_branch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .flag_wr_valid(flag_wr_valid), .alu_opcode(alu_opcode), .alu_flags(alu_flags),
    .br_valid(br_valid), .br_cond(br_cond), .br_pc_plus2(br_pc_plus2), .br_imm(br_imm),
    .br_ready(br_ready), .br_done(br_done), .br_taken(br_taken),
    .br_pc_next(br_pc_next), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fw, input logic [2:0] op, input logic [2:0] fl,
                               input logic bv, input logic [2:0] cond, input logic [15:0] pc,
                               input logic [8:0] imm);
    flag_wr_valid = fw;
    alu_opcode    = op;
    alu_flags     = fl;
    br_valid      = bv;
    br_cond       = cond;
    br_pc_plus2   = pc;
    br_imm        = imm;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(0, 3'b000, 3'b000, 0, 3'b000, 16'h0000, 9'h000);
    #12;
    checkOutput("rst_flags", 16'(flags), 16'h0);
    checkOutput("rst_done", 16'(br_done), 16'h0);
    checkOutput("rst_taken", 16'(br_taken), 16'h0);
    checkOutput("rst_pc", br_pc_next, 16'h0000);
    checkOutput("rst_ready", 16'(br_ready), 16'h1);
    rst_n = 1'b1;
    tick();

    applyStimulus(1, 3'b000, 3'b100, 0, 3'b000, 16'h0000, 9'h000);
    tick();
    checkOutput("add_write", 16'(flags), 16'h4);
    applyStimulus(1, 3'b011, 3'b011, 0, 3'b000, 16'h0000, 9'h000);
    tick();
    checkOutput("red_nowrite", 16'(flags), 16'h4);
    applyStimulus(1, 3'b010, 3'b011, 0, 3'b000, 16'h0000, 9'h000);
    tick();
    checkOutput("xor_zonly", 16'(flags), 16'h0);
    applyStimulus(1, 3'b000, 3'b100, 0, 3'b000, 16'h0000, 9'h000);
    tick();

    // EQ taken, backward offset
    applyStimulus(0, 3'b000, 3'b000, 1, 3'b001, 16'h0010, 9'h1FE);
    tick();
    checkOutput("eq_done", 16'(br_done), 16'h1);
    checkOutput("eq_taken", 16'(br_taken), 16'h1);
    checkOutput("eq_pc", br_pc_next, 16'h000C);
    applyStimulus(0, 3'b000, 3'b000, 0, 3'b000, 16'h0000, 9'h000);
    tick();
    checkOutput("eq_done_drop", 16'(br_done), 16'h0);

    applyStimulus(1, 3'b000, 3'b000, 0, 3'b000, 16'h0000, 9'h000);
    tick();
    checkOutput("flags_clear", 16'(flags), 16'h0);
    applyStimulus(0, 3'b000, 3'b000, 1, 3'b011, 16'hFFFE, 9'h001);
    tick();
    checkOutput("lt_done", 16'(br_done), 16'h1);
    checkOutput("lt_taken", 16'(br_taken), 16'h0);
    checkOutput("lt_pc", br_pc_next, 16'hFFFE);
    applyStimulus(0, 3'b000, 3'b000, 1, 3'b111, 16'hFFFE, 9'h001);
    tick();
    checkOutput("al_taken", 16'(br_taken), 16'h1);
    checkOutput("al_pc_wrap", br_pc_next, 16'h0000);

    // SUB write 010 together with OV branch
    applyStimulus(1, 3'b001, 3'b010, 1, 3'b110, 16'h0100, 9'h004);
    tick();
    applyStimulus(0, 3'b000, 3'b000, 0, 3'b000, 16'h0000, 9'h000);
    checkOutput("cf_flags", 16'(flags), 16'h2);
`ifndef FLAG_BYPASS_EN
    checkOutput("cf_ready_low", 16'(br_ready), 16'h0);
    checkOutput("cf_done_n1", 16'(br_done), 16'h0);
    tick();
`endif
    checkOutput("cf_done", 16'(br_done), 16'h1);
    checkOutput("cf_taken", 16'(br_taken), 16'h1);
    checkOutput("cf_pc", br_pc_next, 16'h0108);
    checkOutput("cf_ready", 16'(br_ready), 16'h1);
    tick();

`ifndef FLAG_BYPASS_EN
    // Conflict, then flush in HOLD
    applyStimulus(1, 3'b000, 3'b100, 1, 3'b001, 16'h0200, 9'h000);
    tick();
    applyStimulus(0, 3'b000, 3'b000, 0, 3'b000, 16'h0000, 9'h000);
    checkOutput("fl_hold", 16'(br_ready), 16'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("fl_done", 16'(br_done), 16'h0);
    checkOutput("fl_ready", 16'(br_ready), 16'h1);
    checkOutput("fl_flags", 16'(flags), 16'h4);
    tick();
    checkOutput("fl_done_after", 16'(br_done), 16'h0);

    // Conflict, stall two cycles in HOLD
    applyStimulus(1, 3'b001, 3'b000, 1, 3'b000, 16'h0300, 9'h1FF);
    tick();
    applyStimulus(1, 3'b000, 3'b100, 0, 3'b000, 16'h0000, 9'h000);
    stall = 1'b1;
    tick();
    checkOutput("st_done1", 16'(br_done), 16'h0);
    checkOutput("st_ready1", 16'(br_ready), 16'h0);
    checkOutput("st_flags_frozen", 16'(flags), 16'h0);
    tick();
    checkOutput("st_done2", 16'(br_done), 16'h0);
    applyStimulus(0, 3'b000, 3'b000, 0, 3'b000, 16'h0000, 9'h000);
    stall = 1'b0;
    tick();
    checkOutput("st_done", 16'(br_done), 16'h1);
    checkOutput("st_taken", 16'(br_taken), 16'h1);
    checkOutput("st_pc", br_pc_next, 16'h02FE);

    // Reset while in HOLD
    applyStimulus(1, 3'b000, 3'b100, 1, 3'b111, 16'h0400, 9'h000);
    tick();
    applyStimulus(0, 3'b000, 3'b000, 0, 3'b000, 16'h0000, 9'h000);
    checkOutput("rh_hold", 16'(br_ready), 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rh_flags", 16'(flags), 16'h0);
    checkOutput("rh_taken", 16'(br_taken), 16'h0);
    checkOutput("rh_pc", br_pc_next, 16'h0000);
    checkOutput("rh_ready", 16'(br_ready), 16'h1);
    rst_n = 1'b1;
    tick();
    checkOutput("rh_done_after", 16'(br_done), 16'h0);
`else
    // Stall holds a bypass-resolved result frozen
    applyStimulus(1, 3'b001, 3'b000, 1, 3'b000, 16'h0300, 9'h1FF);
    tick();
    applyStimulus(0, 3'b000, 3'b000, 0, 3'b000, 16'h0000, 9'h000);
    checkOutput("bp_done", 16'(br_done), 16'h1);
    checkOutput("bp_pc", br_pc_next, 16'h02FE);
    stall = 1'b1;
    tick();
    checkOutput("bp_stall_done", 16'(br_done), 16'h1);
    stall = 1'b0;
    tick();
    checkOutput("bp_done_drop", 16'(br_done), 16'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
